// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: 8-bit LED sequencer (SHIFT/INTERLEAVE/BOUNCE/BLINK) with debounced advance key and pause.
// Latency: led is registered and trails state/step by 1 clk; pause freezes playback. Build option: LED_INVERT_EN (active-low LEDs).
module led_seq_ctrl #(
    parameter int TICK_DIV = 500,
    parameter int DEB_CNT  = 16,
    parameter int REPEAT   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_n,
    input  logic       pause,
    output logic [7:0] led,
    output logic [1:0] pat_id,
    output logic       pat_done
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REPEAT) + 1;
    localparam int DW = $clog2(DEB_CNT + 1);
`ifdef LED_INVERT_EN
    localparam logic [7:0] LED_XOR = 8'hFF;
`else
    localparam logic [7:0] LED_XOR = 8'h00;
`endif

    typedef enum logic [1:0] {
        SHIFT      = 2'd0,
        INTERLEAVE = 2'd1,
        BOUNCE     = 2'd2,
        BLINK      = 2'd3
    } pat_e;

    pat_e          state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          sync1_q, sync2_q, armed_q;
    logic [1:0]    warm_q;
    logic [DW-1:0] deb_q;
    logic          press, tick, auto_adv, advance;
    logic [7:0]    pat_led;

    // armed only after a genuine high level has passed the synchronizer, so a key held through reset is ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            warm_q  <= 2'd0;
            deb_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            if (!warm_q[1])
                warm_q <= warm_q + 2'd1;
            if (sync2_q)
                deb_q <= '0;
            else if (deb_q != DW'(DEB_CNT))
                deb_q <= deb_q + 1'b1;
            if (press)
                armed_q <= 1'b0;
            else if (sync2_q && warm_q[1])
                armed_q <= 1'b1;
        end
    end

    assign press    = armed_q && !sync2_q && (deb_q == DW'(DEB_CNT - 1));
    assign tick     = (tick_q == TW'(TICK_DIV - 1)) && !pause;
    assign auto_adv = tick && (step_q == 3'd7) && (rep_q == RW'(REPEAT - 1));
    assign advance  = press || auto_adv;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rep_d   = rep_q;
        tick_d  = tick_q;
        if (advance) begin
            state_d = pat_e'(state_q + 2'd1);
            step_d  = 3'd0;
            rep_d   = '0;
            tick_d  = '0;
        end else if (!pause) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (tick) begin
                step_d = step_q + 3'd1;
                if (step_q == 3'd7)
                    rep_d = rep_q + 1'b1;
            end
        end
    end

    always_comb begin
        pat_led = 8'h00;
        case (state_q)
            SHIFT:      pat_led = 8'h01 << step_q;
            INTERLEAVE: pat_led = 8'h01 << {step_q[1:0], step_q[2]};
            BOUNCE: begin
                case (step_q)
                    3'd0, 3'd7: pat_led = 8'h81;
                    3'd1, 3'd6: pat_led = 8'h42;
                    3'd2, 3'd5: pat_led = 8'h24;
                    default:    pat_led = 8'h18;
                endcase
            end
            BLINK:      pat_led = step_q[0] ? 8'h00 : 8'hFF;
            default:    pat_led = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= SHIFT;
            step_q   <= 3'd0;
            rep_q    <= '0;
            tick_q   <= '0;
            led      <= 8'h01 ^ LED_XOR;
            pat_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            rep_q    <= rep_d;
            tick_q   <= tick_d;
            led      <= pat_led ^ LED_XOR;
            pat_done <= advance;
        end
    end

    assign pat_id = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios with literal expectations plus randomized key/pause/reset
// traffic, all checked each cycle against a step-counting reference model.
module tb_led_seq_ctrl;
    localparam int TD  = 4;
    localparam int DEB = 3;
    localparam int REP = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_n = 1'b1;
    logic       pause = 1'b0;
    logic [7:0] led;
    logic [1:0] pat_id;
    logic       pat_done;

    int checks = 0;
    int errors = 0;

    led_seq_ctrl #(.TICK_DIV(TD), .DEB_CNT(DEB), .REPEAT(REP)) dut (
        .clk(clk), .rstn(rstn), .key_n(key_n), .pause(pause),
        .led(led), .pat_id(pat_id), .pat_done(pat_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] table_led(input int pat, input int s);
        logic [7:0] v;
        int order [8];
        int bnc [8];
        order = '{0, 2, 4, 6, 1, 3, 5, 7};
        bnc   = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        case (pat)
            0:       v = 8'(1 << s);
            1:       v = 8'(1 << order[s]);
            2:       v = 8'(bnc[s]);
            default: v = (s % 2 == 0) ? 8'hFF : 8'h00;
        endcase
`ifdef LED_INVERT_EN
        v = ~v;
`endif
        return v;
    endfunction

    // reference model: pattern index, cycles played, steps played in the current pattern
    int         m_pat = 0, m_phase = 0, m_ticks = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_led = table_led(0, 0);
    int         rawq[$];
    int         syncq[$];
    int         m_s;
    bit         m_press, m_tick, m_adv;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pat = 0; m_phase = 0; m_ticks = 0; m_done = 1'b0;
            m_led = table_led(0, 0);
            rawq.delete();
            syncq.delete();
        end else begin
            // level seen through two synchronizer stages; -1 marks pre-reset contents
            m_s = (rawq.size() >= 2) ? rawq[$-1] : -1;
            syncq.push_back(m_s);
            rawq.push_back(int'(key_n));
            m_press = (syncq.size() > DEB) && (syncq[$-DEB] == 1);
            for (int i = 0; i < DEB; i++)
                if (syncq.size() <= DEB || syncq[$-i] != 0) m_press = 1'b0;
            m_tick = !pause && (m_phase % TD == TD - 1);
            m_adv  = m_press || (m_tick && m_ticks == 8 * REP - 1);
            m_led  = table_led(m_pat, m_ticks % 8);
            if (m_adv) begin
                m_pat = (m_pat + 1) % 4; m_phase = 0; m_ticks = 0;
            end else if (!pause) begin
                m_phase++;
                if (m_tick) m_ticks++;
            end
            m_done = m_adv;
            if (rawq.size() > 40) void'(rawq.pop_front());
            if (syncq.size() > 40) void'(syncq.pop_front());
        end
    end

    always @(negedge clk) begin
        check("led", led, m_led);
        check("pat_id", 8'(pat_id), 8'(m_pat));
        check("pat_done", 8'(pat_done), 8'(m_done));
    end

    task automatic reset_dut();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_led", led, table_led(0, 0));
        check("rst_pat_id", 8'(pat_id), 8'h00);
        check("rst_pat_done", 8'(pat_done), 8'h00);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold;

    initial begin
        // free run: SHIFT then INTERLEAVE
        wait_n(3);
        check("por_led", led, 8'h01);
        check("por_pat_id", 8'(pat_id), 8'h00);
        rstn = 1'b1;
        wait_n(5);
        check("shift_s1", led, table_led(0, 1));
        check("shift_s1_lit", led, 8'h02);
        wait_n(58);
        check("shift_s7_lit", led, 8'h80);
        check("pre_adv_pat", 8'(pat_id), 8'h00);
        wait_n(1);
        check("auto_adv_pat", 8'(pat_id), 8'h01);
        check("auto_adv_done", 8'(pat_done), 8'h01);
        wait_n(1);
        check("done_1clk", 8'(pat_done), 8'h00);
        check("il_s0_lit", led, 8'h01);
        wait_n(4);
        check("il_s1_lit", led, 8'h04);
        wait_n(12);
        check("il_s4_lit", led, 8'h02);

        // short glitch ignored, long press advances once
        reset_dut();
        wait_n(10);
        key_n = 1'b0; wait_n(2); key_n = 1'b1;
        wait_n(10);
        check("glitch_no_adv", 8'(pat_id), 8'h00);
        key_n = 1'b0; wait_n(10); key_n = 1'b1;
        wait_n(10);
        check("press_one_adv", 8'(pat_id), 8'h01);

        // press lands on the final step-7 tick: single advance
        reset_dut();
        wait_n(59);
        key_n = 1'b0;
        wait_n(5);
        check("coinc_pat", 8'(pat_id), 8'h01);
        wait_n(5);
        check("coinc_no_double", 8'(pat_id), 8'h01);
        key_n = 1'b1;

        // pause freezes, press while paused advances and holds step 0
        reset_dut();
        wait_n(10);
        pause = 1'b1;
        wait_n(50);
        check("pause_led_lit", led, 8'h04);
        key_n = 1'b0; wait_n(8); key_n = 1'b1;
        wait_n(5);
        check("pause_press_pat", 8'(pat_id), 8'h01);
        check("pause_press_led", led, 8'h01);
        wait_n(20);
        check("pause_hold_led", led, 8'h01);
        pause = 1'b0;
        wait_n(30);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    key_n = 1'b0; hold = $urandom_range(1, 8);
                end else begin
                    key_n = 1'b1; hold = $urandom_range(1, 30);
                end
            end else begin
                hold--;
            end
            if ($urandom_range(0, 99) == 0) pause = ~pause;
            if ($urandom_range(0, 1499) == 0) reset_dut();
        end
        reset_dut();
        wait_n(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
